// File: rtl/program_encoder.sv
// program_encoder: serializes program blocks into the byte-record image
// read back by the program decoder, one RAM byte per clock.
module program_encoder #(
  parameter int SIZE                = 16,
  parameter int DATA_BLOCK_MAX_SIZE = 64,
  parameter int MEM_ADDR_BITS       = $clog2(SIZE)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                finish,
  output logic                                ready,
  output logic                                done,
  output logic                                error,
  input  logic [7:0]                          block_length,
  input  logic [15:0]                         block_address,
  input  logic [7:0]                          block_type,
  input  logic [DATA_BLOCK_MAX_SIZE-1:0][7:0] block_data,
  output logic [MEM_ADDR_BITS-1:0]            mem_addr,
  output logic [7:0]                          mem_data,
  output logic                                mem_we,
  output logic [MEM_ADDR_BITS:0]              bytes_written
);

  localparam int IW = $clog2(DATA_BLOCK_MAX_SIZE);
  localparam logic [16:0] SIZE17 = 17'(SIZE);
  localparam logic [7:0] MAXLEN = 8'(DATA_BLOCK_MAX_SIZE);

  typedef enum logic [3:0] {
    IDLE, HDR_TYPE, HDR_LEN, HDR_AHI, HDR_ALO,
    DATA, END, DONE, ERROR
  } state_t;

  state_t state, nxt;

  logic [MEM_ADDR_BITS:0]              ptr;
  logic [7:0]                          len_q;
  logic [15:0]                         addr_q;
  logic [DATA_BLOCK_MAX_SIZE-1:0][7:0] data_q;
  logic [7:0]                          idx, idx_nxt;
  logic [2:0]                          cnt, cnt_nxt;
  logic                                wr;
  logic [7:0]                          wbyte;
  logic                                accept;
  logic [16:0]                         need;

  // header + data + reserved end record must fit behind ptr
  assign need = 17'(ptr) + 17'd8 + 17'(block_length);

  always_comb begin
    nxt     = state;
    wr      = 1'b0;
    wbyte   = 8'h00;
    accept  = 1'b0;
    idx_nxt = idx;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (block_length > MAXLEN || need > SIZE17) begin
            nxt = ERROR;
          end else begin
            accept = 1'b1;
            nxt    = HDR_TYPE;
            wr     = 1'b1;
            wbyte  = block_type;
          end
        end else if (finish) begin
          nxt     = END;
          wr      = 1'b1;
          wbyte   = 8'hFF;
          cnt_nxt = 3'd1;
        end
      end
      HDR_TYPE: begin
        nxt   = HDR_LEN;
        wr    = 1'b1;
        wbyte = len_q;
      end
      HDR_LEN: begin
        nxt   = HDR_AHI;
        wr    = 1'b1;
        wbyte = addr_q[15:8];
      end
      HDR_AHI: begin
        nxt   = HDR_ALO;
        wr    = 1'b1;
        wbyte = addr_q[7:0];
      end
      HDR_ALO: begin
        if (len_q != 8'd0) begin
          nxt     = DATA;
          wr      = 1'b1;
          wbyte   = data_q[0];
          idx_nxt = 8'd1;
        end else begin
          nxt = IDLE;
        end
      end
      DATA: begin
        if (idx == len_q) begin
          nxt = IDLE;
        end else begin
          wr      = 1'b1;
          wbyte   = data_q[idx[IW-1:0]];
          idx_nxt = idx + 8'd1;
        end
      end
      END: begin
        if (cnt == 3'd4) begin
          nxt = DONE;
        end else begin
          wr      = 1'b1;
          cnt_nxt = cnt + 3'd1;
        end
      end
      DONE:    nxt = DONE;
      ERROR:   nxt = ERROR;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      idx      <= '0;
      cnt      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state  <= nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      mem_we <= wr;
      if (accept) begin
        len_q  <= block_length;
        addr_q <= block_address;
        data_q <= block_data;
      end
      if (wr) begin
        mem_addr <= ptr[MEM_ADDR_BITS-1:0];
        mem_data <= wbyte;
        ptr      <= ptr + 1'b1;
      end
    end
  end

  assign ready         = (state == IDLE);
  assign done          = (state == DONE);
  assign error         = (state == ERROR);
  assign bytes_written = ptr;

endmodule

// File: tb/tb_program_encoder.sv
// tb_program_encoder: directed blocks with a write scoreboard popped
// by a negedge monitor, plus handshake/latency checks.
module tb_program_encoder;

  localparam int SIZE = 16;
  localparam int MAXB = 64;
  localparam int AW   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 finish = 1'b0;
  logic                 ready, done, error, mem_we;
  logic [7:0]           block_length, block_type, mem_data;
  logic [15:0]          block_address;
  logic [MAXB-1:0][7:0] block_data;
  logic [AW-1:0]        mem_addr;
  logic [AW:0]          bytes_written;

  int          total = 0;
  int          bad = 0;
  int          exp_ptr = 0;
  logic [11:0] q[$];
  logic [11:0] exp_w;
  logic [MAXB-1:0][7:0] d;

  program_encoder #(
    .SIZE(SIZE),
    .DATA_BLOCK_MAX_SIZE(MAXB),
    .MEM_ADDR_BITS(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .finish(finish),
    .ready(ready),
    .done(done),
    .error(error),
    .block_length(block_length),
    .block_address(block_address),
    .block_type(block_type),
    .block_data(block_data),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_we(mem_we),
    .bytes_written(bytes_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h want none",
                 mem_addr, mem_data);
      end else begin
        exp_w = q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(exp_w[11:8]));
        chk("wr_data", 32'(mem_data), 32'(exp_w[7:0]));
      end
    end
  end

  task automatic push(input logic [7:0] b);
    q.push_back({4'(exp_ptr), b});
    exp_ptr++;
  endtask

  task automatic reset_chk(input string nm);
    chk({nm, "_ready"}, 32'(ready), 1);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_error"}, 32'(error), 0);
    chk({nm, "_we"}, 32'(mem_we), 0);
    chk({nm, "_addr"}, 32'(mem_addr), 0);
    chk({nm, "_data"}, 32'(mem_data), 0);
    chk({nm, "_bw"}, 32'(bytes_written), 0);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0;
    #1;
    reset_chk(nm);
    q.delete();
    exp_ptr = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic scramble();
    block_type    = 8'h77;
    block_length  = 8'd1;
    block_address = 16'hDEAD;
    block_data    = {MAXB{8'h5A}};
  endtask

  task automatic send(input logic [7:0] t, input logic [7:0] l,
                      input logic [15:0] a,
                      input logic [MAXB-1:0][7:0] dd,
                      input bit fin, input bit ok, input bit poke);
    int cyc;
    block_type    = t;
    block_length  = l;
    block_address = a;
    block_data    = dd;
    start         = 1'b1;
    finish        = fin;
    if (ok) begin
      push(t);
      push(l);
      push(a[15:8]);
      push(a[7:0]);
      for (int i = 0; i < int'(l); i++) push(dd[i]);
    end
    @(posedge clk);
    #1;
    start  = poke;
    finish = 1'b0;
    scramble();
    if (!ok) begin
      start = 1'b0;
      chk("err_flag", 32'(error), 1);
      chk("err_ready", 32'(ready), 0);
      chk("err_we", 32'(mem_we), 0);
    end else begin
      chk("busy_ready", 32'(ready), 0);
      cyc = 0;
      while (!ready && cyc < 100) begin
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == 2) start = 1'b0;
      end
      start = 1'b0;
      chk("turnaround", 32'(cyc), 32'(4 + int'(l)));
    end
  endtask

  task automatic do_finish();
    int cyc;
    finish = 1'b1;
    push(8'hFF);
    push(8'h00);
    push(8'h00);
    push(8'h00);
    @(posedge clk);
    #1;
    finish = 1'b0;
    chk("fin_ready", 32'(ready), 0);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("finish_lat", 32'(cyc), 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    scramble();
    d = '0;
    #1;
    rst = 1'b0;
    #1;
    reset_chk("por");
    @(negedge clk);
    rst = 1'b1;

    // length-2 block with start pokes while busy
    d = '0;
    d[0] = 8'hAA;
    d[1] = 8'hBB;
    send(8'h01, 8'd2, 16'h1234, d, 1'b0, 1'b1, 1'b1);
    chk("bw_6", 32'(bytes_written), 6);

    // need = 6+4+3+4 = 17 > 16
    send(8'h02, 8'd3, 16'h0000, d, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 32'(error), 1);
    chk("err_ready2", 32'(ready), 0);
    chk("err_bw", 32'(bytes_written), 6);

    // fill exactly to SIZE: need = 6+4+2+4 = 16
    do_reset("rst2");
    send(8'h01, 8'd2, 16'h1234, d, 1'b0, 1'b1, 1'b0);
    d[0] = 8'hC3;
    d[1] = 8'h3C;
    send(8'h10, 8'd2, 16'hABCD, d, 1'b0, 1'b1, 1'b0);
    chk("bw_12", 32'(bytes_written), 12);
    do_finish();
    chk("bw_16", 32'(bytes_written), 16);
    block_length = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_sticky", 32'(done), 1);
    chk("done_ready", 32'(ready), 0);
    chk("done_bw", 32'(bytes_written), 16);

    // len 0, simultaneous start+finish, length limit
    do_reset("rst3");
    send(8'h03, 8'd0, 16'h0F0F, d, 1'b0, 1'b1, 1'b0);
    chk("bw_4", 32'(bytes_written), 4);
    d[0] = 8'h99;
    send(8'h04, 8'd1, 16'h8000, d, 1'b1, 1'b1, 1'b0);
    chk("sim_done", 32'(done), 0);
    chk("sim_bw", 32'(bytes_written), 9);
    send(8'h05, 8'd65, 16'h0000, d, 1'b0, 1'b0, 1'b0);
    chk("len_bw", 32'(bytes_written), 9);

    // asynchronous reset in the middle of DATA
    do_reset("rst4");
    d = '0;
    d[0] = 8'h11;
    d[1] = 8'h22;
    d[2] = 8'h33;
    d[3] = 8'h44;
    block_type    = 8'h07;
    block_length  = 8'd4;
    block_address = 16'h4242;
    block_data    = d;
    start = 1'b1;
    push(8'h07);
    push(8'h04);
    push(8'h42);
    push(8'h42);
    for (int i = 0; i < 4; i++) push(d[i]);
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_we", 32'(mem_we), 1);
    chk("pre_rst_addr", 32'(mem_addr), 5);
    do_reset("async");

    d[0] = 8'hE7;
    send(8'h06, 8'd1, 16'h0001, d, 1'b0, 1'b1, 1'b0);
    chk("post_bw", 32'(bytes_written), 5);
    do_finish();
    chk("post_done", 32'(done), 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_encoder.md
# program_encoder

Serializes program blocks into the byte-record image that the program decoder consumes, writing it through a synchronous RAM write port one byte per clock. It sits upstream of program storage: a host-side block source drives one block per `start`, and `finish` closes the image with an end record. It is the writer counterpart of the ROM-plus-decoder reader path and uses the same `start`/`ready`/`done` block handshake.

## Interface
- `SIZE`, 16, image RAM size in bytes.
- `DATA_BLOCK_MAX_SIZE`, 64, maximum data bytes per block.
- `MEM_ADDR_BITS`, `$clog2(SIZE)`, RAM address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  accept the block on the `block_*` inputs; honoured only when `ready`=1.
- `finish`  in  1  write the end record and terminate; honoured only when `ready`=1.
- `ready`  out  1  idle and able to accept `start` or `finish`.
- `done`  out  1  end record written; sticky.
- `error`  out  1  block rejected (too long or does not fit); sticky.
- `block_length`  in  8  number of data bytes.
- `block_address`  in  16  target address.
- `block_type`  in  8  block type. 0xFF is reserved for the end record.
- `block_data`  in  8 x `DATA_BLOCK_MAX_SIZE`  data bytes; index 0 is written first.
- `mem_addr`  out  `MEM_ADDR_BITS`  RAM write address.
- `mem_data`  out  8  RAM write data.
- `mem_we`  out  1  RAM write strobe.
- `bytes_written`  out  `MEM_ADDR_BITS`+1  current image length (write pointer).

## Operation
- **Record format:** `[type][length][addr_hi][addr_lo][data0..data(length-1)]`, packed contiguously from RAM address 0.
- **End record:** `[0xFF][0x00][0x00][0x00]`.
- **States:** IDLE, HDR_TYPE, HDR_LEN, HDR_AHI, HDR_ALO, DATA, END, DONE, ERROR.
- **Block accept (IDLE, `start`=1):**
  - Latch `block_type`, `block_length`, `block_address` and `block_data`.
  - Compute `need = ptr + 4 + length + 4` in 17-bit unsigned arithmetic. The trailing 4 reserves room for the end record.
  - If `length > DATA_BLOCK_MAX_SIZE` or `need > SIZE`, go to ERROR and write nothing.
  - Otherwise go to HDR_TYPE.
- **Header sequence:** HDR_TYPE → HDR_LEN → HDR_AHI → HDR_ALO, one byte written per state.
  - From HDR_ALO, go to DATA if length > 0, else to IDLE.
  - DATA writes `data[idx]` with idx running 0..length-1, then goes to IDLE.
- **Finish (IDLE, `finish`=1, `start`=0):** END writes the 4 end-record bytes using an internal byte counter, then goes to DONE.
- **Pointer:** `ptr` increments by 1 on every write. It never wraps, because the fit check guarantees `ptr` ≤ SIZE.
- **Simultaneous `start` and `finish` in IDLE:** `start` wins and `finish` is dropped.
- **Inputs outside IDLE:** `start` and `finish` are ignored in every state other than IDLE. `block_*` inputs may change freely after the accept edge.
- **DONE and ERROR:** both are terminal until reset. `ready`=0 in both.
- **Image after finish:** the end record always fits, so `finish` never produces an error.

## Timing
- **Reset values:**
  - `ready`=1, `done`=0, `error`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - `bytes_written`=0, state=IDLE.
- **Reset mid-operation:** returns immediately to the reset values. Partial records already in RAM are not cleaned up.
- **Registered write port:**
  - `mem_we`, `mem_addr` and `mem_data` are registered and valid together.
  - The first write appears the cycle after the accept edge.
  - Writes occur on consecutive cycles with no gaps.
- **Block latency:**
  - A block occupies 4+length write cycles.
  - `ready` goes low on the cycle after the accept edge.
  - `ready` returns to 1 on the cycle after the last write.
  - Minimum turnaround between accepts is 5 cycles (length 0).
- **Finish latency:** 4 write cycles, then `done`=1 on the following cycle.
- **Error:** `error`=1 on the cycle after the rejecting `start` edge, with no `mem_we` pulse.
- **`ready`** is exactly (state == IDLE).
- **`bytes_written`** updates on the same edge as each write.

## Test plan
- **Length-2 block, SIZE=16:** `start` with type 0x01, len 2, addr 0x1234, data {0xAA,0xBB} → writes 01,02,12,34,AA,BB at addresses 0..5 on 6 consecutive cycles; `ready` returns on the 7th cycle; `bytes_written`=6.
- **Finish after that block:** `finish` → writes FF,00,00,00 at addresses 6..9; `done`=1 one cycle later; subsequent `start` is ignored.
- **Overflow, SIZE=16, ptr=6:** `start` with len 3 (need=17) → `error`=1 next cycle, no writes, `ready`=0; a len-2 block at ptr=6 (need=16) is accepted.
- **Length limit:** len=65 with `DATA_BLOCK_MAX_SIZE`=64 → `error`, no writes. Len=0 → 4 header writes only; `ready` back after 5 cycles.
- **Simultaneous and busy inputs:** `start`+`finish` in the same cycle → block written, no end record. `start` pulses while busy → ignored and the output bytes are unchanged.
- **Reset mid-operation:** drop `rst` during DATA → outputs return to reset values asynchronously; after release, a new block writes from address 0.
